float_div_ieee_e8_m23_iter: RTL

- Iterative IEEE-754 single-precision divider x = a / b, one quotient bit per cycle.
- Inverse-operation companion to the pipelined E8/M23 multiplier in the float_div cache library.
- Same split-field operand interface (sign/exp/man) and rm encoding as the multiplier, plus the same astall global stall.
- Start/done handshake; fixed latency, so schedulers can treat it as a multicycle resource.

---
 rtl/float_div_pkg.sv | 31 +++
 rtl/float_div_round_e8_m23.sv | 57 +++++
 rtl/float_div_ieee_e8_m23_iter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/float_div_pkg.sv
// float_div_pkg: shared constants and types for the E8/M23 iterative divider.
// Holds rounding-mode encodings, field widths, the canonical quiet NaN and
// largest finite magnitude, the divider FSM states, and an operand classifier.
package float_div_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int BIAS   = 127;
    localparam int Q_BITS = 26;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] MAXF = 32'h7F7F_FFFF;

    typedef enum logic [1:0] {IDLE, DIV, ROUND} state_t;
    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} opclass_t;

    // Denormals classify as ZERO (inputs are flushed before division).
    function automatic opclass_t classify(input logic [EXP_W-1:0] e,
                                          input logic [MAN_W-1:0] m);
        if (e == '0)       return ZERO;
        else if (e == '1)  return (m != '0) ? NAN : INF;
        else               return NORM;
    endfunction

endpackage

// File: rtl/float_div_round_e8_m23.sv
// float_div_round_e8_m23: combinational rounding / range stage.
// Ports:
//   sign      result sign
//   e         10-bit signed biased exponent of sig (already normalised)
//   sig       24-bit significand with explicit leading one
//   g, s      guard and sticky bits below sig
//   rm        rounding mode (5-7 behave as RNE)
//   res       packed {sign, exp, man} result
//   of/uf/nx  overflow, flushed-tiny, inexact indications
module float_div_round_e8_m23
    import float_div_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] e,
    input  logic [23:0]       sig,
    input  logic              g,
    input  logic              s,
    input  logic [2:0]        rm,
    output logic [31:0]       res,
    output logic              of,
    output logic              uf,
    output logic              nx
);

    logic              inc;
    logic              to_inf;
    logic [24:0]       sum;
    logic signed [9:0] e_r;

    always_comb begin
        inc    = 1'b0;
        to_inf = 1'b1;
        case (rm)
            RM_RTZ: begin inc = 1'b0;              to_inf = 1'b0;  end
            RM_RDN: begin inc = sign & (g | s);    to_inf = sign;  end
            RM_RUP: begin inc = ~sign & (g | s);   to_inf = ~sign; end
            RM_RMM: begin inc = g;                 to_inf = 1'b1;  end
            default: begin inc = g & (s | sig[0]); to_inf = 1'b1;  end
        endcase

        // A carry out of the significand means the value rounded up to 2.0:
        // bump the exponent and the stored mantissa becomes all zeros.
        sum = {1'b0, sig} + {24'b0, inc};
        e_r = e + $signed({9'b0, sum[24]});

        of = (e_r >= 10'sd255);
        uf = ~of & (e_r <= 10'sd0);
        nx = g | s | of | uf;

        res = {sign, e_r[7:0], sum[24] ? 23'h0 : sum[22:0]};
        if (of)
            res = to_inf ? {sign, 8'hFF, 23'h0} : {sign, MAXF[30:0]};
        else if (uf)
            res = {sign, 31'h0};
    end

endmodule

// File: rtl/float_div_ieee_e8_m23_iter.sv
// float_div_ieee_e8_m23_iter: iterative IEEE-754 single-precision divider,
// x = a / b, one restoring-division quotient bit per cycle.
// Fixed latency: start accepted at cycle 0, done at cycle 27 (26 DIV + ROUND),
// special operands included. DAZ on inputs, FTZ on results.
// Ports:
//   aclk, areset    clock (rising), asynchronous active-high reset
//   astall          global stall, freezes all state including done
//   start           operand valid, taken only in IDLE when not stalled
//   a_*/b_*         dividend / divisor split fields
//   rm              rounding mode 0 RNE,1 RTZ,2 RDN,3 RUP,4 RMM (5-7 = RNE)
//   busy            high from acceptance until done
//   done            one-cycle result strobe
//   x               packed result, held until the next done
//   flags[4:0]      {NV,DZ,OF,UF,NX}, present only when
//                   FLOAT_DIV_EXC_FLAGS_EN is defined
module float_div_ieee_e8_m23_iter
    import float_div_pkg::*;
(
    input  logic              aclk,
    input  logic              areset,
    input  logic              astall,
    input  logic              start,
    input  logic              a_sign,
    input  logic [EXP_W-1:0]  a_exp,
    input  logic [MAN_W-1:0]  a_man,
    input  logic              b_sign,
    input  logic [EXP_W-1:0]  b_exp,
    input  logic [MAN_W-1:0]  b_man,
    input  logic [2:0]        rm,
    output logic              busy,
    output logic              done,
    output logic [31:0]       x
`ifdef FLOAT_DIV_EXC_FLAGS_EN
    ,
    output logic [4:0]        flags
`endif
);

    state_t            state, state_nx;
    logic [4:0]        cnt;
    logic [24:0]       rem;      // partial remainder, always < 2*divisor
    logic [23:0]       dvs;
    logic [25:0]       quo;
    logic              sgn;
    logic signed [9:0] exq;
    logic [2:0]        rmq;
    logic              spec;
    logic [31:0]       spec_x;

    // ---------------- operand classification (IDLE inputs) ----------------
    opclass_t    ca, cb;
    logic        sp_sign, sp_hit, sp_nv, sp_dz;
    logic [31:0] sp_val;

    always_comb begin
        ca      = classify(a_exp, a_man);
        cb      = classify(b_exp, b_man);
        sp_sign = a_sign ^ b_sign;
        sp_hit  = 1'b1;
        sp_nv   = 1'b0;
        sp_dz   = 1'b0;
        sp_val  = {sp_sign, 31'h0};
        if (ca == NAN || cb == NAN || (ca == ZERO && cb == ZERO) ||
            (ca == INF && cb == INF)) begin
            sp_val = QNAN;
            sp_nv  = 1'b1;
        end else if (ca == INF) begin
            sp_val = {sp_sign, 8'hFF, 23'h0};
        end else if (cb == ZERO) begin
            sp_val = {sp_sign, 8'hFF, 23'h0};
            sp_dz  = 1'b1;
        end else if (ca == ZERO || cb == INF) begin
            sp_val = {sp_sign, 31'h0};
        end else begin
            sp_hit = 1'b0;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)       state <= IDLE;
        else if (!astall) state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && !astall) state_nx = DIV;
            DIV:     if (cnt == 5'(Q_BITS - 1)) state_nx = ROUND;
            ROUND:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // ---------------- normalisation + rounding ----------------
    logic              sticky, g_n, s_n;
    logic [23:0]       sig_n;
    logic signed [9:0] e_n;
    logic [31:0]       rnd_res;
    logic              rnd_of, rnd_uf, rnd_nx;

    always_comb begin
        sticky = |rem;
        if (quo[25]) begin
            sig_n = quo[25:2];
            g_n   = quo[1];
            s_n   = quo[0] | sticky;
            e_n   = exq;
        end else begin
            sig_n = quo[24:1];
            g_n   = quo[0];
            s_n   = sticky;
            e_n   = exq - 10'sd1;
        end
    end

    float_div_round_e8_m23 u_round (
        .sign (sgn),
        .e    (e_n),
        .sig  (sig_n),
        .g    (g_n),
        .s    (s_n),
        .rm   (rmq),
        .res  (rnd_res),
        .of   (rnd_of),
        .uf   (rnd_uf),
        .nx   (rnd_nx)
    );

    // ---------------- datapath ----------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt    <= '0;
            rem    <= '0;
            dvs    <= '0;
            quo    <= '0;
            sgn    <= 1'b0;
            exq    <= '0;
            rmq    <= RM_RNE;
            spec   <= 1'b0;
            spec_x <= '0;
            x      <= '0;
            done   <= 1'b0;
        end else if (!astall) begin
            done <= (state == ROUND);
            case (state)
                IDLE: if (start) begin
                    cnt    <= '0;
                    rem    <= {2'b01, a_man};
                    dvs    <= {1'b1, b_man};
                    quo    <= '0;
                    sgn    <= sp_sign;
                    exq    <= $signed({2'b0, a_exp}) - $signed({2'b0, b_exp})
                              + 10'sd127;
                    rmq    <= (rm > RM_RMM) ? RM_RNE : rm;
                    spec   <= sp_hit;
                    spec_x <= sp_val;
                end
                DIV: begin
                    cnt <= cnt + 5'd1;
                    if (rem >= {1'b0, dvs}) begin
                        rem <= (rem - {1'b0, dvs}) << 1;
                        quo <= {quo[24:0], 1'b1};
                    end else begin
                        rem <= rem << 1;
                        quo <= {quo[24:0], 1'b0};
                    end
                end
                ROUND: x <= spec ? spec_x : rnd_res;
                default: ;
            endcase
        end
    end

`ifdef FLOAT_DIV_EXC_FLAGS_EN
    logic nv_q, dz_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            nv_q  <= 1'b0;
            dz_q  <= 1'b0;
            flags <= '0;
        end else if (!astall) begin
            if (state == IDLE && start) begin
                nv_q <= sp_nv;
                dz_q <= sp_dz;
            end
            if (state == ROUND)
                flags <= spec ? {nv_q, dz_q, 3'b000}
                              : {2'b00, rnd_of, rnd_uf, rnd_nx};
        end
    end
`else
    logic unused_flag_bits;
    assign unused_flag_bits = ^{rnd_of, rnd_uf, rnd_nx, sp_nv, sp_dz};
`endif

endmodule
